// File: rtl/versatile_fifo_sync_ctrl_if.sv
// Producer/consumer-side bundle of the versatile_fifo_sync_ctrl FIFO controller.
// The master modport belongs to the logic that pushes and pops words.
// The slave modport belongs to the controller.
// When VERSATILE_FIFO_FILL_LEVEL_EN is defined, the bundle also carries fill, almost_full and almost_empty.
interface versatile_fifo_sync_ctrl_if #(
    parameter int DATA_WIDTH = 8
`ifdef VERSATILE_FIFO_FILL_LEVEL_EN
    , parameter int ADDR_WIDTH = 9
`endif
);
    logic                  flush;
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  wr_en;
    logic                  full;
    logic                  rd_en;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  empty;
    logic                  overflow;
    logic                  underflow;
`ifdef VERSATILE_FIFO_FILL_LEVEL_EN
    logic [ADDR_WIDTH:0]   fill;
    logic                  almost_full;
    logic                  almost_empty;
`endif

    modport master (
        output flush, wr_data, wr_en, rd_en,
        input  full, rd_data, empty, overflow, underflow
`ifdef VERSATILE_FIFO_FILL_LEVEL_EN
        , input fill, almost_full, almost_empty
`endif
    );

    modport slave (
        input  flush, wr_data, wr_en, rd_en,
        output full, rd_data, empty, overflow, underflow
`ifdef VERSATILE_FIFO_FILL_LEVEL_EN
        , output fill, almost_full, almost_empty
`endif
    );
endinterface

// File: rtl/versatile_fifo_sync_ctrl.sv
// First-word-fall-through FIFO controller for one simple dual-port synchronous RAM.
// Port A writes and port B reads; the RAM registers the port B address internally.
// The controller owns the pointers, the occupancy count, full/empty, the sticky error flags and flush.
// Defining VERSATILE_FIFO_FILL_LEVEL_EN adds fill, almost_full and almost_empty.
// It also adds the AF_LEVEL and AE_LEVEL parameters.
module versatile_fifo_sync_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 9
`ifdef VERSATILE_FIFO_FILL_LEVEL_EN
    , parameter int AF_LEVEL = 2**ADDR_WIDTH - 2
    , parameter int AE_LEVEL = 2
`endif
) (
    input  logic                              clk,
    input  logic                              rst,
    versatile_fifo_sync_ctrl_if.slave         fifo,
    output logic [DATA_WIDTH-1:0]             ram_d_a_o,
    output logic [ADDR_WIDTH-1:0]             ram_adr_a_o,
    output logic                              ram_we_a_o,
    output logic [ADDR_WIDTH-1:0]             ram_adr_b_o,
    input  logic [DATA_WIDTH-1:0]             ram_q_b_i
);
    localparam int                  CW    = ADDR_WIDTH + 1;
    localparam logic [ADDR_WIDTH:0] DEPTH = {1'b1, {ADDR_WIDTH{1'b0}}};
`ifdef VERSATILE_FIFO_FILL_LEVEL_EN
    localparam logic [ADDR_WIDTH:0] AF_LVL = CW'(AF_LEVEL);
    localparam logic [ADDR_WIDTH:0] AE_LVL = CW'(AE_LEVEL);
`endif

    // NOTE: the RAM itself is never cleared; the pointers and count alone define which words are valid.
    logic [ADDR_WIDTH-1:0] wptr_q, wptr_d;
    logic [ADDR_WIDTH-1:0] rptr_q, rptr_d;
    logic [ADDR_WIDTH:0]   count_q, count_d;
    logic                  full_q, empty_q, overflow_q, underflow_q;
    logic                  push, pop;
`ifdef VERSATILE_FIFO_FILL_LEVEL_EN
    logic [ADDR_WIDTH:0]   fill_q;
    logic                  almost_full_q, almost_empty_q;
`endif

    // Accept or reject push/pop, then derive the next pointers, the next count and the RAM read address.
    always_comb begin
        // NOTE: every variable gets a value on every path through this block, so no latch is inferred.
        push    = fifo.wr_en & ~full_q  & ~fifo.flush & ~rst;
        pop     = fifo.rd_en & ~empty_q & ~fifo.flush & ~rst;
        wptr_d  = push ? wptr_q + ADDR_WIDTH'(1) : wptr_q;
        rptr_d  = pop  ? rptr_q + ADDR_WIDTH'(1) : rptr_q;
        count_d = count_q + CW'(push) - CW'(pop);
        // Look one word ahead on a pop so the RAM presents the new head on the next cycle.
        ram_adr_b_o = (rst || fifo.flush) ? '0 : rptr_d;
    end

    // Register the pointers, the count and the status flags; reset takes priority over flush.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments keep every register sampling the pre-edge values.
        if (rst || fifo.flush) begin
            wptr_q      <= '0;
            rptr_q      <= '0;
            count_q     <= '0;
            full_q      <= 1'b0;
            empty_q     <= 1'b1;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
`ifdef VERSATILE_FIFO_FILL_LEVEL_EN
            fill_q         <= '0;
            almost_full_q  <= 1'b0;
            almost_empty_q <= 1'b1;
`endif
        end else begin
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            count_q     <= count_d;
            full_q      <= (count_d == DEPTH);
            empty_q     <= (count_d == '0);
            overflow_q  <= overflow_q  | (fifo.wr_en & full_q);
            underflow_q <= underflow_q | (fifo.rd_en & empty_q);
`ifdef VERSATILE_FIFO_FILL_LEVEL_EN
            fill_q         <= count_d;
            almost_full_q  <= (count_d >= AF_LVL);
            almost_empty_q <= (count_d <= AE_LVL);
`endif
        end
    end

    assign ram_d_a_o      = fifo.wr_data;
    assign ram_adr_a_o    = wptr_q;
    assign ram_we_a_o     = push;
    assign fifo.rd_data   = ram_q_b_i;
    assign fifo.full      = full_q;
    assign fifo.empty     = empty_q;
    assign fifo.overflow  = overflow_q;
    assign fifo.underflow = underflow_q;
`ifdef VERSATILE_FIFO_FILL_LEVEL_EN
    assign fifo.fill         = fill_q;
    assign fifo.almost_full  = almost_full_q;
    assign fifo.almost_empty = almost_empty_q;
`endif
endmodule

// File: tb/tb_versatile_fifo_sync_ctrl.sv
// Testbench for versatile_fifo_sync_ctrl with a depth of 4.
// A behavioural RAM with a registered read address sits alongside the controller.
// A queue-based model supplies the expected value of every output.
// When VERSATILE_FIFO_FILL_LEVEL_EN is defined, the bench also checks the fill-level outputs.
module tb_versatile_fifo_sync_ctrl;
    localparam int DW    = 8;
    localparam int AW    = 2;
    localparam int DEPTH = 4;
    localparam int AF    = 3;
    localparam int AE    = 1;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    versatile_fifo_sync_ctrl_if #(
        .DATA_WIDTH(DW)
`ifdef VERSATILE_FIFO_FILL_LEVEL_EN
        , .ADDR_WIDTH(AW)
`endif
    ) fifo ();

    logic [DW-1:0] ram_d_a, ram_q_b;
    logic [AW-1:0] ram_adr_a, ram_adr_b;
    logic          ram_we_a;

    versatile_fifo_sync_ctrl #(
        .DATA_WIDTH(DW),
        .ADDR_WIDTH(AW)
`ifdef VERSATILE_FIFO_FILL_LEVEL_EN
        , .AF_LEVEL(AF)
        , .AE_LEVEL(AE)
`endif
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .fifo        (fifo),
        .ram_d_a_o   (ram_d_a),
        .ram_adr_a_o (ram_adr_a),
        .ram_we_a_o  (ram_we_a),
        .ram_adr_b_o (ram_adr_b),
        .ram_q_b_i   (ram_q_b)
    );

    // Simple dual-port sync RAM: the write and the read-address register update on the same edge.
    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] adr_b_q;
    always @(posedge clk) begin
        if (ram_we_a) mem[ram_adr_a] <= ram_d_a;
        adr_b_q <= ram_adr_b;
    end
    assign ram_q_b = mem[adr_b_q];

    // Reference model: the queued words, the total pushes/pops since the last clear, and the sticky flags.
    logic [DW-1:0] mq[$];
    int            wr_cnt, rd_cnt;
    bit            m_ovf, m_unf;
    int            checks, errors;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_clear();
        mq.delete();
        wr_cnt = 0;
        rd_cnt = 0;
        m_ovf  = 1'b0;
        m_unf  = 1'b0;
    endtask

    // Drive one cycle of inputs, check every output against the model, then advance the model.
    task automatic step(input bit r, input bit fl, input bit we, input logic [DW-1:0] wd, input bit re);
        bit do_push, do_pop;
        rst          = r;
        fifo.flush   = fl;
        fifo.wr_en   = we;
        fifo.wr_data = wd;
        fifo.rd_en   = re;
        @(negedge clk);
        check("empty",     fifo.empty,     mq.size() == 0);
        check("full",      fifo.full,      mq.size() == DEPTH);
        check("overflow",  fifo.overflow,  m_ovf);
        check("underflow", fifo.underflow, m_unf);
        if (mq.size() > 0) check("rd_data", fifo.rd_data, mq[0]);
`ifdef VERSATILE_FIFO_FILL_LEVEL_EN
        check("fill",         fifo.fill,         mq.size());
        check("almost_full",  fifo.almost_full,  mq.size() >= AF);
        check("almost_empty", fifo.almost_empty, mq.size() <= AE);
`endif
        do_push = !r && !fl && we && (mq.size() < DEPTH);
        do_pop  = !r && !fl && re && (mq.size() > 0);
        check("ram_we_a", ram_we_a, do_push);
        if (do_push) begin
            check("ram_adr_a", ram_adr_a, wr_cnt % DEPTH);
            check("ram_d_a",   ram_d_a,   wd);
        end
        check("ram_adr_b", ram_adr_b, (r || fl) ? 0 : (rd_cnt + (do_pop ? 1 : 0)) % DEPTH);
        if (r || fl) begin
            model_clear();
        end else begin
            if (we && mq.size() == DEPTH) m_ovf = 1'b1;
            if (re && mq.size() == 0)     m_unf = 1'b1;
            if (do_pop)  begin void'(mq.pop_front()); rd_cnt++; end
            if (do_push) begin mq.push_back(wd);      wr_cnt++; end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        checks = 0;
        errors = 0;
        model_clear();

        // Hold reset for three clocks with push and pop requested; no write and read address 0.
        rst = 1'b1; fifo.flush = 1'b0; fifo.wr_en = 1'b1; fifo.wr_data = 8'h33; fifo.rd_en = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_empty",     fifo.empty,     1);
        check("rst_full",      fifo.full,      0);
        check("rst_overflow",  fifo.overflow,  0);
        check("rst_underflow", fifo.underflow, 0);
        check("rst_adr_b",     ram_adr_b,      0);
        check("rst_we_a",      ram_we_a,       0);
        @(posedge clk);
        #1;

        // Fill to depth, overflow on the fifth push, then drain back-to-back.
        for (int i = 0; i < 4; i++) step(0, 0, 1, 8'hA1 + 8'(i), 0);
        check("full_after_4", fifo.full, 1);
        step(0, 0, 1, 8'hA5, 0);
        for (int i = 0; i < 4; i++) step(0, 0, 0, 8'h00, 1);
        step(0, 0, 0, 8'h00, 0);
        check("empty_after_drain", fifo.empty, 1);

        // A push into an empty FIFO is visible next cycle; a pop in the same cycle underflows.
        step(0, 0, 1, 8'h55, 1);
        check("fwft_rd_data", fifo.rd_data, 8'h55);
        check("fwft_underflow", fifo.underflow, 1);

        // Steady occupancy of 2 with simultaneous push/pop wrapping both pointers.
        step(0, 0, 1, 8'h66, 0);
        for (int i = 0; i < 10; i++) step(0, 0, 1, 8'h10 + 8'(i), 1);

        // Flush with three queued words and overflow set, then push to address 0.
        step(0, 0, 1, 8'h77, 0);
        step(0, 1, 1, 8'h99, 0);
        step(0, 0, 1, 8'h88, 0);
        check("post_flush_rd", fifo.rd_data, 8'h88);

        // Randomized traffic with phases biased toward filling, draining and streaming.
        for (int i = 0; i < 3000; i++) begin
            int wp, rp;
            case ((i / 250) % 4)
                0:       begin wp = 80; rp = 20; end
                1:       begin wp = 20; rp = 80; end
                2:       begin wp = 50; rp = 50; end
                default: begin wp = 95; rp = 95; end
            endcase
            step(($urandom % 300) == 0, ($urandom % 100) == 0,
                 $urandom_range(0, 99) < wp, 8'($urandom), $urandom_range(0, 99) < rp);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
